// File: rtl/load_store_unit.sv
// load_store_unit
//
// Initiator-side load/store unit. Takes one load or store request at a time
// from the core and sequences a word-wide, byte-addressed memory port (A, WD,
// WE, combinational RD). The port has no byte enables, so byte and halfword
// stores are done as read-modify-write. The IO word at 32'h7FFFFFFC is the
// exception: sub-word stores to it are written zero-extended, with no read.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   Req, IsStore, Funct3,      request strobe (sampled only when idle),
//   Addr, StoreData            direction, RISC-V width code, address, data
//   LoadData                   registered, extended load result
//   Done, Fault, Busy          completion pulse, fault flag, not-idle flag
//   A, WD, WE, RD              memory port
//
// Configuration macro:
//   LSU_ALIGN_CHECK_EN  when defined, misaligned W/H/HU accesses fault.
//                       When undefined, only illegal width codes fault.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Req
// RDC   | read cycle: load capture, or merge-word capture for SB/SH
// WRC   | write cycle: WE high for exactly this one cycle
// FIN   | normal completion, Done=1
// ERR   | fault completion, Done=1 Fault=1, no write, LoadData kept

module load_store_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        Busy,
    output logic        Fault,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD
);

    localparam logic [31:0] IO_ADDR = 32'h7FFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDC  = 3'd1,
        S_WRC  = 3'd2,
        S_FIN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_data_q, load_data_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [31:0] load_ext;

    // Request decode, evaluated on the live inputs while idle.
    always_comb begin
        req_illegal = 1'b0;
        if (IsStore) begin
            req_illegal = (Funct3 != 3'b000) && (Funct3 != 3'b001) && (Funct3 != 3'b010);
        end else begin
            req_illegal = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        req_misaligned = 1'b0;
        if (Funct3[1:0] == 2'b10) begin
            req_misaligned = (Addr[1:0] != 2'b00);
        end else if (Funct3[1:0] == 2'b01) begin
            req_misaligned = Addr[0];
        end
    end
`else
    assign req_misaligned = 1'b0;
`endif

    // Load extension from the latched width code.
    always_comb begin
        load_ext = RD;
        case (funct3_q)
            3'b000:  load_ext = {{24{RD[7]}}, RD[7:0]};
            3'b001:  load_ext = {{16{RD[15]}}, RD[15:0]};
            3'b100:  load_ext = {24'b0, RD[7:0]};
            3'b101:  load_ext = {16'b0, RD[15:0]};
            default: load_ext = RD;
        endcase
    end

    // State register and datapath flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            funct3_q    <= '0;
            is_store_q  <= 1'b0;
            merge_q     <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            merge_q     <= merge_d;
            load_data_q <= load_data_d;
        end
    end

    // Next-state and datapath-next logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        merge_d     = merge_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d     = Addr;
                    sdata_d    = StoreData;
                    funct3_d   = Funct3;
                    is_store_d = IsStore;
                    if (req_illegal || req_misaligned) begin
                        state_d = S_ERR;
                    end else if (!IsStore) begin
                        state_d = S_RDC;
                    end else if ((Funct3 == 3'b010) || (Addr == IO_ADDR)) begin
                        state_d = S_WRC;
                    end else begin
                        state_d = S_RDC;
                    end
                end
            end
            S_RDC: begin
                if (is_store_q) begin
                    merge_d = RD;
                    state_d = S_WRC;
                end else begin
                    load_data_d = load_ext;
                    state_d     = S_FIN;
                end
            end
            S_WRC:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; memory port is parked at zero outside RDC/WRC.
    always_comb begin
        A     = '0;
        WD    = '0;
        WE    = 1'b0;
        Done  = 1'b0;
        Fault = 1'b0;
        Busy  = (state_q != S_IDLE);
        case (state_q)
            S_RDC: begin
                A = addr_q;
            end
            S_WRC: begin
                A  = addr_q;
                WE = 1'b1;
                case (funct3_q[1:0])
                    2'b00:   WD = (addr_q == IO_ADDR) ? {24'b0, sdata_q[7:0]}
                                                      : {merge_q[31:8], sdata_q[7:0]};
                    2'b01:   WD = (addr_q == IO_ADDR) ? {16'b0, sdata_q[15:0]}
                                                      : {merge_q[31:16], sdata_q[15:0]};
                    default: WD = sdata_q;
                endcase
            end
            S_FIN: begin
                Done = 1'b1;
            end
            S_ERR: begin
                Done  = 1'b1;
                Fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign LoadData = load_data_q;

endmodule
